// File: rtl/gru_state_blend.sv
// GRU hidden-state blend: h_new = (1 - z)*h_prev + z*h_cand in signed fixed point,
// three-stage globally stalled pipeline with per-vector element count and clamp status.
module gru_state_blend #(
    parameter int DATA_WIDTH  = 8,
    parameter int FRAC_BITS   = 4,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_z,
    input  logic [DATA_WIDTH-1:0]  in_h_prev,
    input  logic [DATA_WIDTH-1:0]  in_h_cand,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_h,
    output logic                   out_last,
    output logic [COUNT_WIDTH-1:0] out_count,
    output logic                   out_clamped
);

    localparam int DW = DATA_WIDTH;
    localparam int PW = 2 * DW + 1;
    localparam int SW = 2 * DW + 2;
    localparam logic signed [DW:0]   ONE = (DW + 1)'(1 << FRAC_BITS);
    localparam logic signed [SW-1:0] RND = SW'(1 << (FRAC_BITS - 1));

    logic en;

    // stage 1
    logic                 v1_q, v1_d, last1_q, last1_d, clamp1_q, clamp1_d;
    logic signed [DW:0]   zc_q, zc_d, omz_q, omz_d;
    logic signed [DW-1:0] hp_q, hp_d, hc_q, hc_d;
    // stage 2
    logic                 v2_q, v2_d, last2_q, last2_d, clamp2_q, clamp2_d;
    logic signed [PW-1:0] p0_q, p0_d, p1_q, p1_d;
    // stage 3 and vector status
    logic                   out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic                   out_clamped_q, out_clamped_d, sticky_q, sticky_d;
    logic [DW-1:0]          out_h_q, out_h_d;
    logic [COUNT_WIDTH-1:0] out_count_q, out_count_d, cnt_q, cnt_d;

    logic signed [DW:0]   z_ext, zc_n;
    logic                 clamp_n;
    logic signed [SW-1:0] sum, shifted;

    assign en       = !out_valid_q || out_ready;
    assign in_ready = en;

    always_comb begin
        z_ext   = {in_z[DW-1], in_z};
        zc_n    = z_ext;
        clamp_n = 1'b0;
        if (z_ext[DW]) begin
            zc_n    = '0;
            clamp_n = 1'b1;
        end else if (z_ext > ONE) begin
            zc_n    = ONE;
            clamp_n = 1'b1;
        end

        sum     = SW'(p0_q) + SW'(p1_q) + RND;
        shifted = sum >>> FRAC_BITS;

        v1_d          = v1_q;
        zc_d          = zc_q;
        omz_d         = omz_q;
        hp_d          = hp_q;
        hc_d          = hc_q;
        last1_d       = last1_q;
        clamp1_d      = clamp1_q;
        v2_d          = v2_q;
        p0_d          = p0_q;
        p1_d          = p1_q;
        last2_d       = last2_q;
        clamp2_d      = clamp2_q;
        out_valid_d   = out_valid_q;
        out_h_d       = out_h_q;
        out_last_d    = out_last_q;
        out_count_d   = out_count_q;
        out_clamped_d = out_clamped_q;
        cnt_d         = cnt_q;
        sticky_d      = sticky_q;

        if (en) begin
            v1_d     = in_valid;
            zc_d     = zc_n;
            omz_d    = ONE - zc_n;
            hp_d     = in_h_prev;
            hc_d     = in_h_cand;
            last1_d  = in_last;
            clamp1_d = clamp_n;

            v2_d     = v1_q;
            p0_d     = PW'(omz_q) * PW'(hp_q);
            p1_d     = PW'(zc_q) * PW'(hc_q);
            last2_d  = last1_q;
            clamp2_d = clamp1_q;

            out_valid_d = v2_q;
            if (v2_q) begin
                out_h_d       = shifted[DW-1:0];
                out_last_d    = last2_q;
                out_count_d   = cnt_q + COUNT_WIDTH'(1);
                out_clamped_d = sticky_q | clamp2_q;
                // status restarts on the element after a last, so vectors can abut
                cnt_d    = last2_q ? '0 : cnt_q + COUNT_WIDTH'(1);
                sticky_d = last2_q ? 1'b0 : (sticky_q | clamp2_q);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q          <= 1'b0;
            zc_q          <= '0;
            omz_q         <= '0;
            hp_q          <= '0;
            hc_q          <= '0;
            last1_q       <= 1'b0;
            clamp1_q      <= 1'b0;
            v2_q          <= 1'b0;
            p0_q          <= '0;
            p1_q          <= '0;
            last2_q       <= 1'b0;
            clamp2_q      <= 1'b0;
            out_valid_q   <= 1'b0;
            out_h_q       <= '0;
            out_last_q    <= 1'b0;
            out_count_q   <= '0;
            out_clamped_q <= 1'b0;
            cnt_q         <= '0;
            sticky_q      <= 1'b0;
        end else begin
            v1_q          <= v1_d;
            zc_q          <= zc_d;
            omz_q         <= omz_d;
            hp_q          <= hp_d;
            hc_q          <= hc_d;
            last1_q       <= last1_d;
            clamp1_q      <= clamp1_d;
            v2_q          <= v2_d;
            p0_q          <= p0_d;
            p1_q          <= p1_d;
            last2_q       <= last2_d;
            clamp2_q      <= clamp2_d;
            out_valid_q   <= out_valid_d;
            out_h_q       <= out_h_d;
            out_last_q    <= out_last_d;
            out_count_q   <= out_count_d;
            out_clamped_q <= out_clamped_d;
            cnt_q         <= cnt_d;
            sticky_q      <= sticky_d;
        end
    end

    // the blend lies between h_prev and h_cand, so the dropped high bits are sign copies
    always_ff @(posedge clk) begin
        if (!rst && en && v2_q) begin
            assert (shifted[SW-1:DW-1] == '0 || shifted[SW-1:DW-1] == '1);
        end
    end

    assign out_valid   = out_valid_q;
    assign out_h       = out_h_q;
    assign out_last    = out_last_q;
    assign out_count   = out_count_q;
    assign out_clamped = out_clamped_q;

endmodule
